uart_tx_fifo: RTL and testbench

- Parametrised UART transmitter with an input FIFO, configurable frame format and CTS flow control.
- Successor to the fixed-format 8N1 transmit path in the Apple-1 core.
- Serves two roles: the TX side of the apple1 top-level UART, and a synthesizable stimulus source that drives the core's uart_rx input in simulation benches.
- Host-side writes queue bytes; the block serialises them LSB-first at a baud rate derived from the clock.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, configurable frame format and CTS flow control.
// Bytes are queued by the host and serialised LSB-first. Each bit lasts CLK_HZ/BAUD clocks.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk25,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [DATA_BITS-1:0]            wr_data,
  input  logic                            cts,
  output logic                            tx,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow,
  output logic                            busy
);

  localparam int unsigned BAUD_DIV = ((CLK_HZ / BAUD) < 1) ? 1 : (CLK_HZ / BAUD);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_nxt;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 baud_end;

  // A write is accepted only against the registered full flag, even if a pop frees a slot.
  assign push     = wr_en && !full;
  assign pop      = (state_q == StIdle) && !empty && cts;
  assign head     = mem_q[rd_ptr_q];
  assign par_bit  = (PARITY == 2) ? ^head : ~^head;
  assign baud_end = (cnt_q == CNT_W'(BAUD_DIV - 1));

  // Next occupancy from the push/pop pair.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (!push && pop) begin
      level_nxt = level - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk25) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, registered flags and sticky overflow.
  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
      empty <= (level_nxt == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Frame sequencer; tx and busy are registered alongside the state.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= StIdle;
      tx         <= 1'b1;
      busy       <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tx <= 1'b1;
          if (pop) begin
            shift_q <= head;
            par_q   <= par_bit;
            cnt_q   <= '0;
            state_q <= StStart;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (baud_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx        <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                state_q <= StParity;
                tx      <= par_q;
              end else begin
                state_q    <= StStop;
                stop_idx_q <= 1'b0;
                tx         <= 1'b1;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx        <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (baud_end) begin
            cnt_q      <= '0;
            state_q    <= StStop;
            stop_idx_q <= 1'b0;
            tx         <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          tx <= 1'b1;
          if (baud_end) begin
            cnt_q <= '0;
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 4, 7O2, 7E2) at 4 clocks per bit.
// Queued bytes go into per-instance scoreboards; the frame receiver pops and compares them.
module tb_uart_tx_fifo;

  localparam int BD = 4;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic       rst;
  logic       wr_en_a, cts_a;
  logic [7:0] wr_data_a;
  logic       tx_a, full_a, empty_a, overflow_a, busy_a;
  logic [2:0] level_a;

  logic       wr_en_b, cts_b;
  logic [6:0] wr_data_b;
  logic       tx_b, full_b, empty_b, overflow_b, busy_b;
  logic [2:0] level_b;
  logic       tx_c, full_c, empty_c, overflow_c, busy_c;
  logic [2:0] level_c;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4)) u_a (
    .clk25(clk25), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a), .cts(cts_a),
    .tx(tx_a), .full(full_a), .empty(empty_a), .level(level_a), .overflow(overflow_a),
    .busy(busy_a)
  );

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                 .FIFO_DEPTH(4)) u_b (
    .clk25(clk25), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .cts(cts_b),
    .tx(tx_b), .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b),
    .busy(busy_b)
  );

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(4)) u_c (
    .clk25(clk25), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .cts(cts_b),
    .tx(tx_c), .full(full_c), .empty(empty_c), .level(level_c), .overflow(overflow_c),
    .busy(busy_c)
  );

  task automatic tick;
    @(negedge clk25);
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Wait for a start bit, pop the expected byte and compare every bit of the frame.
  // waited = cycles until tx fell; busy_cnt = cycles with busy high over the frame.
  task automatic recv(input int sel, input int nbits, input int par, input int nstop,
                      input string name, output int waited, output int busy_cnt);
    logic [7:0]  d;
    logic [11:0] exp_b, act_b;
    logic        p, t;
    bit          unstable;
    int          total, pb;
    waited = 0;
    busy_cnt = 0;
    unstable = 1'b0;
    exp_b = '0;
    act_b = '0;
    while (tx_of(sel) !== 1'b0 && waited < 200) begin
      tick();
      waited++;
    end
    if (tx_of(sel) !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s start: tx still %b after %0d cycles, required 0", name, tx_of(sel),
               waited);
      return;
    end
    d = '0;
    if (sel == 0 && q_a.size() > 0) d = q_a.pop_front();
    else if (sel == 1 && q_b.size() > 0) d = q_b.pop_front();
    else if (sel == 2 && q_c.size() > 0) d = q_c.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: frame seen, required no frame", name);
    end
    pb = (par != 0) ? 1 : 0;
    total = 1 + nbits + pb + nstop;
    exp_b[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      exp_b[1 + i] = d[i];
      p = p ^ d[i];
    end
    if (par == 1) exp_b[1 + nbits] = ~p;
    if (par == 2) exp_b[1 + nbits] = p;
    for (int i = 0; i < nstop; i++) exp_b[1 + nbits + pb + i] = 1'b1;
    for (int i = 0; i < total; i++) begin
      for (int c = 0; c < BD; c++) begin
        if (!(i == 0 && c == 0)) tick();
        t = tx_of(sel);
        if (c == 0) act_b[i] = t;
        else if (t !== act_b[i]) unstable = 1'b1;
        if (busy_of(sel) === 1'b1) busy_cnt++;
      end
    end
    checks++;
    if (act_b !== exp_b || unstable) begin
      errors++;
      $display("FAIL %s bits (data %h): got %b unstable=%0d, required %b", name, d, act_b,
               unstable, exp_b);
    end
  endtask

  task automatic write_a(input logic [7:0] d, input bit accept);
    wr_en_a = 1'b1;
    wr_data_a = d;
    if (accept) q_a.push_back(d);
    tick();
    wr_en_a = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_en_a = 1'b0; wr_data_a = '0; cts_a = 1'b0;
    wr_en_b = 1'b0; wr_data_b = '0; cts_b = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx_a, full_a, empty_a, level_a, overflow_a, busy_a} !== 8'b1_0_1_000_0_0) begin
      errors++;
      $display("FAIL reset_a: got %b required 10100000",
               {tx_a, full_a, empty_a, level_a, overflow_a, busy_a});
    end
    checks++;
    if ({tx_b, full_b, empty_b, level_b, overflow_b, busy_b} !== 8'b1_0_1_000_0_0) begin
      errors++;
      $display("FAIL reset_b: got %b required 10100000",
               {tx_b, full_b, empty_b, level_b, overflow_b, busy_b});
    end
    checks++;
    if ({tx_c, full_c, empty_c, level_c, overflow_c, busy_c} !== 8'b1_0_1_000_0_0) begin
      errors++;
      $display("FAIL reset_c: got %b required 10100000",
               {tx_c, full_c, empty_c, level_c, overflow_c, busy_c});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int w, b;
    cts_a = 1'b1;
    write_a(8'h41, 1'b1);
    checks++;
    if (level_a !== 3'd1 || empty_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_push: level=%0d empty=%b, required 1 0", level_a, empty_a);
    end
    recv(0, 8, 0, 1, "basic_8n1", w, b);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL basic_latency: start after %0d cycles, required 1", w);
    end
    checks++;
    if (b !== 40) begin
      errors++;
      $display("FAIL basic_busy: busy high %0d cycles, required 40", b);
    end
    tick();
    checks++;
    if ({busy_a, tx_a, empty_a, level_a} !== 6'b0_1_1_000) begin
      errors++;
      $display("FAIL basic_idle: busy/tx/empty/level %b, required 011000",
               {busy_a, tx_a, empty_a, level_a});
    end
  endtask

  task automatic test_parity;
    int w1, b1, w2, b2;
    cts_b = 1'b1;
    wr_en_b = 1'b1;
    wr_data_b = 7'h41;
    q_b.push_back(8'h41);
    q_c.push_back(8'h41);
    tick();
    wr_en_b = 1'b0;
    fork
      recv(1, 7, 1, 2, "frame_7o2", w1, b1);
      recv(2, 7, 2, 2, "frame_7e2", w2, b2);
    join
    checks++;
    if (b1 !== 44 || b2 !== 44) begin
      errors++;
      $display("FAIL parity_len: busy cycles %0d/%0d, required 44/44", b1, b2);
    end
  endtask

  task automatic test_overflow;
    int w, b;
    int bad;
    cts_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_a(8'h10 + 8'(i), i < 4);
      if (i == 3) begin
        checks++;
        if (full_a !== 1'b1 || level_a !== 3'd4 || overflow_a !== 1'b0) begin
          errors++;
          $display("FAIL fifo_full: full=%b level=%0d ovf=%b, required 1 4 0", full_a,
                   level_a, overflow_a);
        end
      end
    end
    checks++;
    if (overflow_a !== 1'b1 || level_a !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b level=%0d, required 1 4", overflow_a, level_a);
    end
    cts_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      recv(0, 8, 0, 1, "ovf_frame", w, b);
      checks++;
      if (w !== ((k == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL ovf_gap frame %0d: start after %0d cycles, required %0d", k, w,
                 (k == 0) ? 1 : 2);
      end
    end
    bad = 0;
    repeat (20) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || overflow_a !== 1'b1 || empty_a !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: extra-activity cycles %0d ovf=%b empty=%b, required 0 1 1",
               bad, overflow_a, empty_a);
    end
  endtask

  task automatic test_cts;
    int w, b;
    int bad;
    cts_a = 1'b0;
    write_a(8'h55, 1'b1);
    write_a(8'hAA, 1'b1);
    cts_a = 1'b1;
    fork
      recv(0, 8, 0, 1, "cts_first", w, b);
      begin
        repeat (10) tick();
        cts_a = 1'b0;
      end
    join
    bad = 0;
    repeat (20) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL cts_hold: %0d cycles not idle with level 1, required 0", bad);
    end
    cts_a = 1'b1;
    recv(0, 8, 0, 1, "cts_second", w, b);
    checks++;
    if (w < 1 || w > 2) begin
      errors++;
      $display("FAIL cts_resume: start after %0d cycles, required 1..2", w);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    cts_a = 1'b0;
    write_a(8'h3C, 1'b1);
    write_a(8'h11, 1'b1);
    write_a(8'h22, 1'b1);
    cts_a = 1'b1;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({tx_a, busy_a, level_a, empty_a, full_a, overflow_a} !== 8'b1_0_000_1_0_0) begin
      errors++;
      $display("FAIL reset_mid: tx/busy/level/empty/full/ovf %b, required 10000100",
               {tx_a, busy_a, level_a, empty_a, full_a, overflow_a});
    end
    rst = 1'b0;
    q_a.delete();
    bad = 0;
    repeat (60) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_quiet: %0d active cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int w, b;
    cts_a = 1'b0;
    write_a(8'h5A, 1'b1);
    wr_en_a = 1'b1;
    wr_data_a = 8'hC3;
    cts_a = 1'b1;
    q_a.push_back(8'hC3);
    tick();
    wr_en_a = 1'b0;
    checks++;
    if (level_a !== 3'd1) begin
      errors++;
      $display("FAIL pushpop_level: level=%0d, required 1", level_a);
    end
    recv(0, 8, 0, 1, "pushpop_first", w, b);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL pushpop_start: start after %0d cycles, required 0", w);
    end
    recv(0, 8, 0, 1, "pushpop_second", w, b);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL pushpop_gap: start after %0d cycles, required 2", w);
    end
    tick();
    checks++;
    if (level_a !== 3'd0 || q_a.size() != 0) begin
      errors++;
      $display("FAIL pushpop_drain: level=%0d pending=%0d, required 0 0", level_a, q_a.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_cts();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
